// File: rtl/pop_pkg.sv
// Shared types and width helpers for the population read-side master.
package pop_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain
    } state_e;

    // Framing flags carried alongside each sample through the output buffer.
    typedef struct packed {
        logic first;
        logic last;
    } beat_tag_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count/full/empty; the head is read directly from storage
// registers, so it is stable while nothing pops.
module sync_fifo
    import pop_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned   PW      = idx_width(DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DepthC);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    // Zero when empty so the outputs read as 0 out of reset without clearing storage.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Upstream credit accounting must never let a write reach a full buffer.
    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/pop_reader.sv
// Read-side master for the population register file: sweeps addresses 0..POPSIZE-1
// on each new_data pulse and forwards the returned samples as a framed valid/ready
// stream. Requests are issued only against free buffer slots because the file's
// one-cycle read return cannot be back-pressured.
module pop_reader
    import pop_pkg::*;
#(
    parameter int unsigned POPSIZE    = 100,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW = idx_width(POPSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_data,
    output logic                  rd_rqst,
    output logic [AW-1:0]         read_addr,
    input  logic                  data_vld,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned   IW      = cnt_width(POPSIZE);
    localparam int unsigned   CW      = cnt_width(FIFO_DEPTH);
    localparam logic [IW-1:0] LastIdx = IW'(POPSIZE - 1);
    localparam logic [CW:0]   DepthC  = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        beat_tag_t             tag;
    } beat_t;

    state_e        state_q;
    logic [IW-1:0] issue_cnt_q;
    logic [IW-1:0] recv_cnt_q;
    logic          inflight_q;
    logic          overrun_q;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credits_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    beat_t         push_beat;
    beat_t         head_beat;

    // Slots already committed: occupied entries plus the read still in flight.
    assign credits_used = {1'b0, fifo_count} + (CW + 1)'(inflight_q);

    assign rd_rqst   = (state_q == StSweep) && (credits_used < DepthC);
    assign read_addr = (state_q == StSweep) ? issue_cnt_q[AW-1:0] : '0;
    assign busy      = (state_q != StIdle);
    assign overrun   = overrun_q;

    // Returns are trusted only when we asked for them the cycle before.
    assign push = data_vld && inflight_q;
    assign pop  = m_valid && m_ready;

    assign m_valid = !fifo_empty;
    assign m_data  = head_beat.data;
    assign m_first = head_beat.tag.first;
    assign m_last  = head_beat.tag.last;

    // Tag each return with its position in the frame.
    always_comb begin
        push_beat           = '0;
        push_beat.data      = data_out;
        push_beat.tag.first = (recv_cnt_q == '0);
        push_beat.tag.last  = (recv_cnt_q == LastIdx);
    end

    // Frame sequencing, issue/receive counters and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            inflight_q <= rd_rqst;
            if (push) begin
                recv_cnt_q <= recv_cnt_q + IW'(1);
            end
            // Includes the DRAIN->IDLE cycle: the frame is still considered busy then.
            if (new_data && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (new_data) begin
                        state_q     <= StSweep;
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                StSweep: begin
                    if (rd_rqst) begin
                        issue_cnt_q <= issue_cnt_q + IW'(1);
                        if (issue_cnt_q == LastIdx) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && head_beat.tag.last) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_beat),
        .pop   (pop),
        .rdata (head_beat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A request is only legal with at least one free slot in the buffer.
    a_rqst_has_room: assert property (@(posedge clk) disable iff (rst) rd_rqst |-> !fifo_full);

    // Addresses issued never leave the population window.
    a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
        rd_rqst |-> (issue_cnt_q <= LastIdx));

endmodule

// File: tb/tb_pop_reader.sv
// Bench for pop_reader: three instances (4/4, 4/2, 100/4 for POPSIZE/FIFO_DEPTH),
// each with a register-file model; expected frames are queued when new_data is
// issued and a monitor thread compares every accepted beat.
module tb_pop_reader;

    localparam int NI    = 3;
    localparam int AWMAX = 7;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             nd   [NI];
    logic             rq   [NI];
    logic             dv   [NI];
    logic [7:0]       dout [NI];
    logic             mv   [NI];
    logic             mr   [NI];
    logic [7:0]       md   [NI];
    logic             mf   [NI];
    logic             ml   [NI];
    logic             bsy  [NI];
    logic             ovr  [NI];
    logic [AWMAX-1:0] addr [NI];

    logic       spur_en;
    logic [7:0] salt2;

    exp_beat_t q0[$];
    exp_beat_t q1[$];
    exp_beat_t q2[$];
    int        outstanding [NI];
    logic      exp_ovr     [NI];
    int        beats       [NI];
    int        checks;
    int        errors;

    function automatic int popsize(input int g);
        return (g == 2) ? 100 : 4;
    endfunction

    function automatic logic [7:0] sample(input int g, input int a);
        if (g == 2) return 8'(a * 3) + salt2;
        return 8'(a + 'h10);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P  = (g == 2) ? 100 : 4;
        localparam int D  = (g == 1) ? 2 : 4;
        localparam int AW = $clog2(P);
        logic [AW-1:0] ra;
        logic          vld_r;
        logic [7:0]    dat_r;

        pop_reader #(
            .POPSIZE    (P),
            .DATA_WIDTH (8),
            .FIFO_DEPTH (D)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .new_data  (nd[g]),
            .rd_rqst   (rq[g]),
            .read_addr (ra),
            .data_vld  (dv[g]),
            .data_out  (dout[g]),
            .m_valid   (mv[g]),
            .m_ready   (mr[g]),
            .m_data    (md[g]),
            .m_first   (mf[g]),
            .m_last    (ml[g]),
            .busy      (bsy[g]),
            .overrun   (ovr[g])
        );

        assign addr[g] = AWMAX'(ra);
        assign dv[g]   = vld_r;
        assign dout[g] = dat_r;

        // Register file: answers one cycle after each request; instance 2 may also
        // raise unrequested data_vld with junk data.
        always @(posedge clk) begin
            vld_r <= rq[g] | ((g == 2) && spur_en && ($urandom_range(3) == 0));
            dat_r <= rq[g] ? sample(g, int'(addr[g])) : 8'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int g, input exp_beat_t b);
        case (g)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic int exp_size(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_beat_t pop_exp(input int g);
        case (g)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic reset_model();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int g = 0; g < NI; g++) begin
            outstanding[g] = 0;
            exp_ovr[g]     = 1'b0;
        end
    endtask

    // One-cycle new_data pulse; a frame is expected only if none is outstanding.
    task automatic issue_frame(input int g);
        int p;
        p = popsize(g);
        if (outstanding[g] > 0) begin
            exp_ovr[g] = 1'b1;
        end else begin
            outstanding[g] = 1;
            for (int a = 0; a < p; a++) begin
                push_exp(g, '{data: sample(g, a), first: (a == 0), last: (a == p - 1)});
            end
        end
        nd[g] = 1'b1;
        tick();
        nd[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n;
        n = 0;
        while (outstanding[g] != 0 && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("frame_done[%0d]", g), outstanding[g], 0);
        check($sformatf("idle_after_frame[%0d]", g), bsy[g], 1'b0);
    endtask

    task automatic check_idle(input int g);
        check($sformatf("all_zero[%0d]", g),
              {rq[g], addr[g], mv[g], md[g], mf[g], ml[g], bsy[g], ovr[g]}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reset_model();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every accepted beat must match the head of its queue.
    task automatic monitor();
        exp_beat_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (!rst && mv[g] && mr[g]) begin
                    if (exp_size(g) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat[%0d]: got %0h expected none", g, md[g]);
                    end else begin
                        e = pop_exp(g);
                        check($sformatf("beat[%0d]", g), {md[g], mf[g], ml[g]},
                              {e.data, e.first, e.last});
                        beats[g]++;
                        if (e.last) outstanding[g]--;
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        int b0;
        int frames;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        spur_en = 1'b0;
        salt2   = 8'h00;
        for (int g = 0; g < NI; g++) begin
            nd[g]    = 1'b0;
            mr[g]    = 1'b0;
            beats[g] = 0;
        end
        reset_model();
        fork
            monitor();
        join_none
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int g = 0; g < NI; g++) check_idle(g);

        // Latency/throughput: new_data in cycle 0, requests 1-4, beats 3-6, idle at 7.
        mr[0] = 1'b1;
        issue_frame(0);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_rqst_c%0d", c), {rq[0], addr[0]},
                  {(c <= 4), (c <= 4) ? AWMAX'(c - 1) : AWMAX'(0)});
            check($sformatf("t1_valid_c%0d", c), mv[0], (c >= 3 && c <= 6));
            check($sformatf("t1_busy_c%0d", c), bsy[0], (c <= 6));
            tick();
        end
        wait_done(0, 5);

        // Back-pressure: issue stops at FIFO_DEPTH credits, head holds, nothing lost.
        mr[0] = 1'b0;
        b0 = beats[0];
        issue_frame(0);
        n = 0;
        repeat (10) begin
            n += int'(rq[0]);
            tick();
        end
        check("t2_issues", n, 4);
        check("t2_head", {mv[0], md[0], mf[0]}, {1'b1, q0[0].data, 1'b1});
        mr[0] = 1'b1;
        wait_done(0, 20);
        check("t2_beats", beats[0] - b0, 4);

        // Two-entry buffer stalled: only two credits available.
        mr[1] = 1'b0;
        issue_frame(1);
        n = 0;
        repeat (8) begin
            n += int'(rq[1]);
            tick();
        end
        check("t3_stall_issues", n, 2);
        mr[1] = 1'b1;
        wait_done(1, 30);

        // Two-entry buffer free-running: the whole frame still gets through.
        issue_frame(1);
        n = 0;
        repeat (12) begin
            n += int'(rq[1]);
            tick();
        end
        check("t3_issues", n, 4);
        wait_done(1, 10);

        // new_data during SWEEP: ignored, overrun sticks through the next frame.
        b0 = beats[0];
        issue_frame(0);
        tick();
        issue_frame(0);
        check("t4_ovr_set", ovr[0], exp_ovr[0]);
        wait_done(0, 20);
        check("t4_no_restart", beats[0] - b0, 4);
        issue_frame(0);
        wait_done(0, 20);
        check("t4_ovr_sticky", ovr[0], exp_ovr[0]);
        do_reset();
        check_idle(0);

        // Reset mid-SWEEP after address 1: outputs clear, pending return discarded.
        issue_frame(0);
        check("t5_rqst0", {rq[0], addr[0]}, {1'b1, AWMAX'(0)});
        tick();
        check("t5_rqst1", {rq[0], addr[0]}, {1'b1, AWMAX'(1)});
        rst = 1'b1;
        reset_model();
        tick();
        rst = 1'b0;
        check_idle(0);
        tick();
        check("t5_discard", {mv[0], bsy[0]}, 0);
        issue_frame(0);
        check("t5_restart", {rq[0], addr[0]}, {1'b1, AWMAX'(0)});
        wait_done(0, 20);

        // new_data on the last-beat cycle (DRAIN->IDLE) still counts as overrun.
        issue_frame(0);
        repeat (5) tick();
        issue_frame(0);
        check("t6_ovr_drain_edge", ovr[0], exp_ovr[0]);
        check("t6_no_restart", {bsy[0], rq[0]}, 0);
        repeat (6) tick();
        check("t6_still_idle", {bsy[0], mv[0]}, 0);
        do_reset();

        // Random back-pressure, three back-to-back 100-sample frames, stray data_vld.
        spur_en = 1'b1;
        b0 = beats[2];
        frames = 0;
        for (int c = 0; c < 3000 && !(frames == 3 && outstanding[2] == 0); c++) begin
            mr[2] = ($urandom_range(1) == 1);
            if (frames < 3 && outstanding[2] == 0) begin
                salt2 = 8'($urandom);
                issue_frame(2);
                frames++;
            end else begin
                tick();
            end
        end
        spur_en = 1'b0;
        mr[2] = 1'b1;
        check("t7_frames", frames, 3);
        wait_done(2, 10);
        check("t7_beats", beats[2] - b0, 300);
        check("t7_ovr", ovr[2], exp_ovr[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
